memory_stage: RTL

//  RV32I MEM stage between execute and writeback. Registers the EX result, runs load/store on a

---
 rtl/memory_stage_pkg.sv | 61 ++++++
 rtl/memory_stage_if.sv | 24 ++
 rtl/memory_stage_load_align.sv | 34 +++
 rtl/memory_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the RV32I MEM stage: decoded-opcode bit indices, funct3 codes,
// FSM encoding and byte-lane helpers.
package memory_stage_pkg;

    localparam int OPCODE_WIDTH = 11;

    // One-hot decoded opcode bit positions
    localparam int OP_RTYPE  = 0;
    localparam int OP_ITYPE  = 1;
    localparam int OP_LOAD   = 2;
    localparam int OP_STORE  = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL    = 5;
    localparam int OP_JALR   = 6;
    localparam int OP_LUI    = 7;
    localparam int OP_AUIPC  = 8;
    localparam int OP_SYSTEM = 9;
    localparam int OP_FENCE  = 10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } mem_state_e;

    // Halfwords pick their lane from a[1] alone so an odd address never spills past the word.
    function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_sel = 4'b0001 << off;
            2'b01:   lane_sel = off[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   store_data = {4{rs2[7:0]}};
            2'b01:   store_data = {2{rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Wishbone-classic data bus between the MEM stage (master) and data memory (slave).
interface memory_stage_if #(
    parameter int DWIDTH = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [DWIDTH-1:0] addr;
    logic [DWIDTH-1:0] dat_w;
    logic [3:0]        sel;
    logic              ack;
    logic              stall;
    logic [DWIDTH-1:0] dat_r;

    modport master (
        output cyc, stb, we, addr, dat_w, sel,
        input  ack, stall, dat_r
    );

    modport slave (
        input  cyc, stb, we, addr, dat_w, sel,
        output ack, stall, dat_r
    );
endinterface

// File: rtl/memory_stage_load_align.sv
// Load lane extraction: selects byte/halfword from the read word and sign/zero extends it.
module mem_load_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_v = lanes[byte_off];
        half_v = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   result = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  result = {24'b0, byte_v};
            F3_LH:   result = {{16{half_v[15]}}, half_v};
            F3_LHU:  result = {16'b0, half_v};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: registers EX results, runs loads/stores on a Wishbone-classic bus.
// Optional MEM_MISALIGN_CHECK_EN rejects misaligned H/W accesses and adds me_o_misaligned.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int PC_WIDTH    = 32,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic                    me_clk,
    input  logic                    me_rst,
    input  logic                    me_i_ce,
    input  logic                    me_i_stall,
    input  logic                    me_i_flush,
    input  logic [OPCODE_WIDTH-1:0] me_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  me_i_funct3,
    input  logic [DWIDTH-1:0]       me_i_alu_value,
    input  logic [DWIDTH-1:0]       me_i_data_rs2,
    input  logic [AWIDTH-1:0]       me_i_addr_rd,
    input  logic                    me_i_we_reg,
    input  logic [PC_WIDTH-1:0]     me_i_pc,
    output logic                    me_o_ce,
    output logic [AWIDTH-1:0]       me_o_addr_rd,
    output logic [DWIDTH-1:0]       me_o_data_rd,
    output logic                    me_o_we_reg,
    output logic [PC_WIDTH-1:0]     me_o_pc,
    output logic                    me_o_stall,
    output logic                    me_o_flush,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic                    me_o_misaligned,
`endif
    memory_stage_if.master          wb
);

    mem_state_e          state_q, state_d;
    logic                cyc_q, cyc_d, stb_q, stb_d, wb_we_q, wb_we_d;
    logic [DWIDTH-1:0]   wb_addr_q, wb_addr_d, wb_data_q, wb_data_d;
    logic [3:0]          wb_sel_q, wb_sel_d;
    logic [2:0]          txn_f3_q, txn_f3_d;
    logic [1:0]          txn_off_q, txn_off_d;
    logic                txn_store_q, txn_store_d, txn_we_q, txn_we_d;
    logic [AWIDTH-1:0]   txn_rd_q, txn_rd_d;
    logic [PC_WIDTH-1:0] txn_pc_q, txn_pc_d;
    logic                discard_q, discard_d;
    logic [DWIDTH-1:0]   hold_data_q, hold_data_d;
    logic                ce_q, ce_d, we_reg_q, we_reg_d, flush_q, flush_d;
    logic [AWIDTH-1:0]   addr_rd_q, addr_rd_d;
    logic [DWIDTH-1:0]   data_rd_q, data_rd_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
`ifdef MEM_MISALIGN_CHECK_EN
    logic                mis_q, mis_d;
`endif

    logic                accept, mem_op, is_store, bad_align, bus_done, kill, finish;
    logic [DWIDTH-1:0]   load_value, result_value;
    logic                unused_opcode_bits;

    assign unused_opcode_bits = ^{me_i_opcode[OPCODE_WIDTH-1:OP_STORE+1], me_i_opcode[OP_LOAD-1:0]};

    mem_load_align u_align (
        .funct3   (txn_f3_q),
        .byte_off (txn_off_q),
        .rdata    (wb.dat_r),
        .result   (load_value)
    );

    assign me_o_stall = (state_q != ST_IDLE) | me_i_stall;
    assign accept     = me_i_ce & ~me_o_stall;
    assign is_store   = me_i_opcode[OP_STORE];
    assign mem_op     = me_i_opcode[OP_LOAD] | is_store;
    assign bus_done   = wb.ack & ((state_q == ST_WAIT) | ((state_q == ST_REQ) & ~wb.stall));
    assign kill       = discard_q | me_i_flush;
`ifdef MEM_MISALIGN_CHECK_EN
    assign bad_align  = is_misaligned(me_i_funct3, me_i_alu_value[1:0]);
`else
    assign bad_align  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        wb_we_d      = wb_we_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        wb_sel_d     = wb_sel_q;
        txn_f3_d     = txn_f3_q;
        txn_off_d    = txn_off_q;
        txn_store_d  = txn_store_q;
        txn_we_d     = txn_we_q;
        txn_rd_d     = txn_rd_q;
        txn_pc_d     = txn_pc_q;
        discard_d    = discard_q;
        hold_data_d  = hold_data_q;
        ce_d         = ce_q;
        we_reg_d     = we_reg_q;
        addr_rd_d    = addr_rd_q;
        data_rd_d    = data_rd_q;
        pc_d         = pc_q;
        flush_d      = me_i_flush;
        finish       = 1'b0;
        result_value = load_value;
`ifdef MEM_MISALIGN_CHECK_EN
        mis_d        = mis_q;
`endif
        // Writeback-facing outputs are single-cycle pulses unless WB is stalling.
        if (!me_i_stall) begin
            ce_d     = 1'b0;
            we_reg_d = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            mis_d    = 1'b0;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && !me_i_flush) begin
                    if (mem_op && !bad_align) begin
                        state_d     = ST_REQ;
                        cyc_d       = 1'b1;
                        stb_d       = 1'b1;
                        wb_we_d     = is_store;
                        wb_addr_d   = {me_i_alu_value[DWIDTH-1:2], 2'b00};
                        wb_sel_d    = lane_sel(me_i_funct3, me_i_alu_value[1:0]);
                        wb_data_d   = store_data(me_i_funct3, me_i_data_rs2);
                        txn_f3_d    = me_i_funct3;
                        txn_off_d   = me_i_alu_value[1:0];
                        txn_store_d = is_store;
                        txn_we_d    = me_i_we_reg;
                        txn_rd_d    = me_i_addr_rd;
                        txn_pc_d    = me_i_pc;
                        discard_d   = 1'b0;
                    end else begin
                        ce_d      = 1'b1;
                        addr_rd_d = me_i_addr_rd;
                        pc_d      = me_i_pc;
                        data_rd_d = mem_op ? '0 : me_i_alu_value;
                        we_reg_d  = ~mem_op & me_i_we_reg & (me_i_addr_rd != '0);
`ifdef MEM_MISALIGN_CHECK_EN
                        mis_d     = mem_op;
`endif
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                if (me_i_flush)
                    discard_d = 1'b1;
                if (state_q == ST_REQ && !wb.stall) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT;
                end
                if (bus_done) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    wb_we_d = 1'b0;
                    // A stalled WB cannot take the result yet; park it until it can.
                    if (me_i_stall) begin
                        hold_data_d = load_value;
                        state_d     = ST_HOLD;
                    end else begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (me_i_flush)
                    discard_d = 1'b1;
                if (!me_i_stall) begin
                    finish       = 1'b1;
                    result_value = hold_data_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            ce_d      = ~kill;
            addr_rd_d = txn_rd_q;
            pc_d      = txn_pc_q;
            data_rd_d = txn_store_q ? '0 : result_value;
            we_reg_d  = txn_we_q & ~txn_store_q & (txn_rd_q != '0) & ~kill;
        end
    end

    always_ff @(posedge me_clk or negedge me_rst) begin
        if (!me_rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_sel_q    <= '0;
            txn_f3_q    <= '0;
            txn_off_q   <= '0;
            txn_store_q <= 1'b0;
            txn_we_q    <= 1'b0;
            txn_rd_q    <= '0;
            txn_pc_q    <= '0;
            discard_q   <= 1'b0;
            hold_data_q <= '0;
            ce_q        <= 1'b0;
            we_reg_q    <= 1'b0;
            addr_rd_q   <= '0;
            data_rd_q   <= '0;
            pc_q        <= '0;
            flush_q     <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            wb_we_q     <= wb_we_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_sel_q    <= wb_sel_d;
            txn_f3_q    <= txn_f3_d;
            txn_off_q   <= txn_off_d;
            txn_store_q <= txn_store_d;
            txn_we_q    <= txn_we_d;
            txn_rd_q    <= txn_rd_d;
            txn_pc_q    <= txn_pc_d;
            discard_q   <= discard_d;
            hold_data_q <= hold_data_d;
            ce_q        <= ce_d;
            we_reg_q    <= we_reg_d;
            addr_rd_q   <= addr_rd_d;
            data_rd_q   <= data_rd_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
`ifdef MEM_MISALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign wb.cyc       = cyc_q;
    assign wb.stb       = stb_q;
    assign wb.we        = wb_we_q;
    assign wb.addr      = wb_addr_q;
    assign wb.dat_w     = wb_data_q;
    assign wb.sel       = wb_sel_q;
    assign me_o_ce      = ce_q;
    assign me_o_addr_rd = addr_rd_q;
    assign me_o_data_rd = data_rd_q;
    assign me_o_we_reg  = we_reg_q;
    assign me_o_pc      = pc_q;
    assign me_o_flush   = flush_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign me_o_misaligned = mis_q;
`endif

endmodule
